// File: rtl/mem_arb_ctl.sv
// Two-requester round-robin arbiter in front of a single-port register-file memory.
// Optional grant locking is compiled in by defining MEM_ARB_LOCK_EN.
module mem_arb_ctl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_G0   = 2'd1;
  localparam logic [1:0] S_G1   = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_ptr;
  logic          w_ptr_nxt;
  logic          w_hold0;
  logic          w_hold1;
  logic [DW-1:0] r_mem [2**AW];

`ifdef MEM_ARB_LOCK_EN
  // A locked owner keeps the memory for as long as it asserts req and lock.
  assign w_hold0 = (r_state == S_G0) && req0 && lock0;
  assign w_hold1 = (r_state == S_G1) && req1 && lock1;
`else
  logic w_unused_lock;
  assign w_unused_lock = lock0 | lock1;
  assign w_hold0       = 1'b0;
  assign w_hold1       = 1'b0;
`endif

  // r_ptr = 0 favours requester 0 on a tie; it flips to the other side after each fresh grant.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_ptr_nxt   = r_ptr;
    if (w_hold0) begin
      w_state_nxt = S_G0;
    end else if (w_hold1) begin
      w_state_nxt = S_G1;
    end else if (req0 && (!req1 || !r_ptr)) begin
      w_state_nxt = S_G0;
      w_ptr_nxt   = 1'b1;
    end else if (req1) begin
      w_state_nxt = S_G1;
      w_ptr_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt0 = (r_state == S_G0);
  assign gnt1 = (r_state == S_G1);

  // Write commits on the edge that ends the grant cycle; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (gnt0 && we0) begin
        r_mem[addr0] <= wdata0;
      end else if (gnt1 && we1) begin
        r_mem[addr1] <= wdata1;
      end
    end
  end

  assign rdata0 = gnt0 ? r_mem[addr0] : '0;
  assign rdata1 = gnt1 ? r_mem[addr1] : '0;

endmodule

// File: tb/tb_mem_arb_ctl.sv
// Scoreboard bench for mem_arb_ctl: each row's expected outputs are queued as the row is
// driven and popped/compared one cycle later. Define MEM_ARB_LOCK_EN to expect locked grants.
module tb_mem_arb_ctl;

  typedef struct packed {
    bit         rst;
    bit         rq0;
    bit         we0;
    logic [3:0] a0;
    logic [7:0] d0;
    bit         lk0;
    bit         rq1;
    bit         we1;
    logic [3:0] a1;
    logic [7:0] d1;
    bit         lk1;
  } stim_t;

  typedef struct packed {
    bit         g0;
    bit         g1;
    bit         c0;
    logic [7:0] r0;
    bit         c1;
    logic [7:0] r1;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1;
  logic [7:0] rdata0, rdata1;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  mem_arb_ctl #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk_s(input bit r, input bit q0, input bit w0, input logic [3:0] a0,
                                 input logic [7:0] d0, input bit l0, input bit q1, input bit w1,
                                 input logic [3:0] a1, input logic [7:0] d1, input bit l1);
    stim_t s;
    s = '{rst: r, rq0: q0, we0: w0, a0: a0, d0: d0, lk0: l0,
          rq1: q1, we1: w1, a1: a1, d1: d1, lk1: l1};
    return s;
  endfunction

  function automatic exp_t mk_e(input bit g0, input bit g1, input bit c0, input logic [7:0] r0,
                                input bit c1, input logic [7:0] r1);
    exp_t e;
    e = '{g0: g0, g1: g1, c0: c0, r0: r0, c1: c1, r1: r1};
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; req0 = s.rq0; we0 = s.we0; addr0 = s.a0; wdata0 = s.d0; lock0 = s.lk0;
    req1 = s.rq1; we1 = s.we1; addr1 = s.a1; wdata1 = s.d1; lock1 = s.lk1;
  endtask

  // REQ-031: reset held two cycles with both requests high.
  task automatic test_reset();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    for (int i = 0; i < 2; i++) begin
      st.push_back(mk_s(1, 1, 0, 4'd0, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0));
      ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    end
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if (gnt0 !== e.g0) $display("FAIL reset gnt0 row%0d got %b want %b", i, gnt0, e.g0); else n_pass++;
      n_total++; if (gnt1 !== e.g1) $display("FAIL reset gnt1 row%0d got %b want %b", i, gnt1, e.g1); else n_pass++;
      n_total++; if (rdata0 !== e.r0) $display("FAIL reset rdata0 row%0d got %h want %h", i, rdata0, e.r0); else n_pass++;
      n_total++; if (rdata1 !== e.r1) $display("FAIL reset rdata1 row%0d got %h want %h", i, rdata1, e.r1); else n_pass++;
    end
  endtask

  // REQ-033/017: both requests high straight out of reset alternate G0,G1,G0,G1.
  task automatic test_tie();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    for (int i = 0; i < 4; i++) begin
      st.push_back(mk_s(0, 1, 0, 4'd0, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0));
      if (i % 2 == 0) ex.push_back(mk_e(1, 0, 0, 8'h00, 1, 8'h00));
      else            ex.push_back(mk_e(0, 1, 1, 8'h00, 0, 8'h00));
    end
    st.push_back(mk_s(0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0));
    ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if (gnt0 !== e.g0) $display("FAIL tie gnt0 row%0d got %b want %b", i, gnt0, e.g0); else n_pass++;
      n_total++; if (gnt1 !== e.g1) $display("FAIL tie gnt1 row%0d got %b want %b", i, gnt1, e.g1); else n_pass++;
      if (e.c0) begin n_total++; if (rdata0 !== e.r0) $display("FAIL tie rdata0 row%0d got %h want %h", i, rdata0, e.r0); else n_pass++; end
      if (e.c1) begin n_total++; if (rdata1 !== e.r1) $display("FAIL tie rdata1 row%0d got %h want %h", i, rdata1, e.r1); else n_pass++; end
    end
  endtask

  // REQ-032/016/022/036: cross-requester write/read, repeated single-requester grants,
  // ignored fields of a non-granted requester, and pre-write rdata in the write cycle.
  task automatic test_write_read();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(mk_s(0, 1, 1, 4'd3, 8'hA5, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(1, 0, 0, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 0, 1, 4'd3, 8'hA5, 0, 1, 0, 4'd3, 8'h00, 0)); ex.push_back(mk_e(0, 1, 1, 8'h00, 1, 8'hA5));
    st.push_back(mk_s(0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    for (int i = 0; i < 3; i++) begin
      st.push_back(mk_s(0, 0, 1, 4'd3, 8'hFF, 0, 1, 0, 4'd3, 8'h00, 0)); ex.push_back(mk_e(0, 1, 1, 8'h00, 1, 8'hA5));
    end
    st.push_back(mk_s(0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 1, 1, 4'd7, 8'h22, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(1, 0, 0, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 0, 1, 4'd7, 8'h22, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 1, 1, 4'd7, 8'h11, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(1, 0, 1, 8'h22, 1, 8'h00));
    st.push_back(mk_s(0, 0, 1, 4'd7, 8'h11, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 1, 0, 4'd7, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(1, 0, 1, 8'h11, 1, 8'h00));
    st.push_back(mk_s(0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if (gnt0 !== e.g0) $display("FAIL wr_rd gnt0 row%0d got %b want %b", i, gnt0, e.g0); else n_pass++;
      n_total++; if (gnt1 !== e.g1) $display("FAIL wr_rd gnt1 row%0d got %b want %b", i, gnt1, e.g1); else n_pass++;
      if (e.c0) begin n_total++; if (rdata0 !== e.r0) $display("FAIL wr_rd rdata0 row%0d got %h want %h", i, rdata0, e.r0); else n_pass++; end
      if (e.c1) begin n_total++; if (rdata1 !== e.r1) $display("FAIL wr_rd rdata1 row%0d got %h want %h", i, rdata1, e.r1); else n_pass++; end
    end
  endtask

  // REQ-034/025/027: reset on the edge ending a write grant drops the write and the request.
  task automatic test_reset_mid_write();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(mk_s(0, 1, 1, 4'd5, 8'h77, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(1, 0, 0, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 0, 1, 4'd5, 8'h77, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 1, 1, 4'd5, 8'h3C, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(1, 0, 1, 8'h77, 1, 8'h00));
    st.push_back(mk_s(1, 1, 1, 4'd5, 8'h3C, 0, 1, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    st.push_back(mk_s(0, 1, 0, 4'd5, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(1, 0, 1, 8'h77, 1, 8'h00));
    st.push_back(mk_s(0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if (gnt0 !== e.g0) $display("FAIL rst_wr gnt0 row%0d got %b want %b", i, gnt0, e.g0); else n_pass++;
      n_total++; if (gnt1 !== e.g1) $display("FAIL rst_wr gnt1 row%0d got %b want %b", i, gnt1, e.g1); else n_pass++;
      if (e.c0) begin n_total++; if (rdata0 !== e.r0) $display("FAIL rst_wr rdata0 row%0d got %h want %h", i, rdata0, e.r0); else n_pass++; end
      if (e.c1) begin n_total++; if (rdata1 !== e.r1) $display("FAIL rst_wr rdata1 row%0d got %h want %h", i, rdata1, e.r1); else n_pass++; end
    end
  endtask

  // REQ-035: req0+lock0 held for four grant cycles against a constant req1.
  task automatic test_lock();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(mk_s(1, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    for (int i = 0; i < 4; i++) begin
      st.push_back(mk_s(0, 1, 0, 4'd0, 8'h00, 1, 1, 0, 4'd0, 8'h00, 0));
`ifdef MEM_ARB_LOCK_EN
      ex.push_back(mk_e(1, 0, 0, 8'h00, 1, 8'h00));
`else
      if (i % 2 == 0) ex.push_back(mk_e(1, 0, 0, 8'h00, 1, 8'h00));
      else            ex.push_back(mk_e(0, 1, 1, 8'h00, 0, 8'h00));
`endif
    end
    st.push_back(mk_s(0, 0, 0, 4'd0, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 1, 1, 8'h00, 0, 8'h00));
    st.push_back(mk_s(0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0)); ex.push_back(mk_e(0, 0, 1, 8'h00, 1, 8'h00));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if (gnt0 !== e.g0) $display("FAIL lock gnt0 row%0d got %b want %b", i, gnt0, e.g0); else n_pass++;
      n_total++; if (gnt1 !== e.g1) $display("FAIL lock gnt1 row%0d got %b want %b", i, gnt1, e.g1); else n_pass++;
      if (e.c0) begin n_total++; if (rdata0 !== e.r0) $display("FAIL lock rdata0 row%0d got %h want %h", i, rdata0, e.r0); else n_pass++; end
      if (e.c1) begin n_total++; if (rdata1 !== e.r1) $display("FAIL lock rdata1 row%0d got %h want %h", i, rdata1, e.r1); else n_pass++; end
    end
  endtask

  initial begin
    drive(mk_s(1, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0));
    test_reset();
    test_tie();
    test_write_read();
    test_reset_mid_write();
    test_lock();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
